seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4: number of multiplexed BCD digits (range 1..16).
REQ-002 The module SHALL have parameter REFRESH_DIV, default 1000: clock cycles per digit slot (minimum 2).
REQ-003 The module SHALL have a single clock domain: clk  input  1  rising-edge clock.
REQ-004 The module SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have bcd_in  input  4*NUM_DIGITS  packed BCD value; digit 0 (least significant) in bits [3:0].
REQ-006 The module SHALL have load  input  1  single-cycle strobe that captures bcd_in.
REQ-007 The module SHALL have seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
REQ-008 The module SHALL have dig_en  output  NUM_DIGITS  one-hot digit enable, active-high, registered.
REQ-009 The module SHALL have frame_done  output  1  one-cycle pulse at the end of each full scan.
REQ-010 The module SHALL have bcd_err  output  1  high while the displayed digit code is 10..15.

Function
REQ-011 The block SHALL contain a prescaler counting 0..REFRESH_DIV-1 ($clog2(REFRESH_DIV) bits) and a digit index counting 0..NUM_DIGITS-1.
REQ-012 When the prescaler equals REFRESH_DIV-1, it SHALL wrap to 0 and the digit index SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-013 frame_done SHALL pulse for exactly one cycle, on the cycle after the digit index wraps to 0.
REQ-014 load=1 SHALL capture bcd_in into a pending register and set a pending flag. A later load in the same frame SHALL overwrite the pending value (last wins).
REQ-015 At each frame wrap, a pending value SHALL be copied into the active register and the pending flag SHALL be cleared. The display SHALL never change value mid-frame.
REQ-016 If load coincides with the frame-wrap cycle, bcd_in SHALL go directly to the active register and the pending flag SHALL be cleared.
REQ-017 Decode SHALL be the standard 7-segment mapping for 0..9. Segment e SHALL be lit only for 0, 2, 6 and 8.
REQ-018 Codes 10..15 SHALL drive seg=7'b0000000 (blank), and bcd_err SHALL be high for that slot.
REQ-019 seg, dig_en and bcd_err SHALL have 1-cycle latency from the digit index/prescaler state.
REQ-020 In the first cycle of every slot (prescaler==0), dig_en SHALL be all-zero (anti-ghost blanking). Otherwise exactly one bit SHALL be set.
REQ-021 With NUM_DIGITS=1, the digit index SHALL stay at 0, and frame_done SHALL pulse every REFRESH_DIV cycles.

Reset
REQ-022 While rst_n=0 at a clk edge, the following SHALL be cleared to 0: prescaler, digit index, active register, pending register, pending flag, seg, dig_en, frame_done and bcd_err.
REQ-023 Reset asserted mid-frame SHALL abort the scan, and any pending value SHALL be discarded.
REQ-024 After reset release, the first slot SHALL be digit 0 showing code 0.

Configuration
REQ-025 Macro SEG7_SCAN_LZ_BLANK_EN SHALL control leading-zero suppression:
  - When defined, every zero digit more significant than the highest nonzero digit SHALL be blanked (seg=0; dig_en still cycles). Digit 0 SHALL never be blanked.
  - When undefined, all digits SHALL be displayed as decoded.
REQ-026 Invalid codes (10..15) SHALL count as nonzero for leading-zero evaluation.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-027 Reset release, no load:
  - dig_en SHALL follow 0000,0001x3,0000,0010x3,... .
  - seg SHALL be 7'b0111111 in every enabled slot.
  - frame_done SHALL pulse every 16 cycles.
REQ-028 load with bcd_in=16'h1234 mid-frame: the display SHALL stay 0000 until the wrap, and the next frame SHALL show digit0=4 (7'b1100110), digit1=3, digit2=2, digit3=1.
REQ-029 load 16'h1111 then load 16'h5678 within the same frame: the next frame SHALL show only 5678.
REQ-030 load 16'h00A9: digit1 SHALL show seg=0 with bcd_err=1 for its slot, and digit0 SHALL show 9 with bcd_err=0.
REQ-031 Macro defined, load 16'h0070: digit3 and digit2 SHALL be blank, digit1 SHALL show 7 and digit0 SHALL show 0. Macro undefined: all four digits SHALL be displayed.
REQ-032 Assert rst_n=0 for 1 cycle during digit2 with load pending: all outputs SHALL be 0 on the next cycle, and the scan SHALL restart at digit 0 with value 0000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed 7-segment scan driver for NUM_DIGITS packed BCD digits.
//   A prescaler divides clk into digit slots of REFRESH_DIV cycles. Each slot
//   lights one digit in turn. New values are double-buffered so that a frame
//   (one pass over all digits) always shows a single consistent value.
//
//   Optional feature: define SEG7_SCAN_LZ_BLANK_EN to blank leading zeros
//   (digit 0 is never blanked). The default build shows every digit.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   bcd_in     in   [4*NUM_DIGITS-1:0] packed BCD, digit 0 in bits [3:0]
//   load       in   single-cycle strobe capturing bcd_in
//   seg        out  [6:0] segments {g,f,e,d,c,b,a}, active-high, registered
//   dig_en     out  [NUM_DIGITS-1:0] one-hot digit enable, registered
//   frame_done out  one-cycle pulse at the start of each new scan
//   bcd_err    out  high while the displayed digit code is 10..15
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done,
  output logic                    bcd_err
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         active_q, active_d;
  logic [BW-1:0]         pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  bcd_err_q, bcd_err_d;

  logic                  slot_end;
  logic                  frame_wrap;
  logic [3:0]            cur_code;
  logic                  lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    slot_end   = (presc_q == PRESC_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);

    presc_d = slot_end ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // The active value only changes at the frame wrap; a load landing on the
    // wrap cycle bypasses the pending buffer so it is not delayed a frame.
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_wrap) begin
      if (load) begin
        active_d = bcd_in;
      end else if (pend_vld_q) begin
        active_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = bcd_in;
      pend_vld_d = 1'b1;
    end

    cur_code = active_q[4*int'(idx_q) +: 4];

`ifdef SEG7_SCAN_LZ_BLANK_EN
    // Blank when this digit and everything above it is zero. Codes 10..15
    // are nonzero, so they stop suppression naturally.
    lz_blank = (idx_q != '0) && ((active_q >> (4*int'(idx_q))) == '0);
`else
    lz_blank = 1'b0;
`endif

    seg_d     = lz_blank ? 7'b0000000 : decode(cur_code);
    bcd_err_d = (cur_code > 4'd9);

    // Dark for the first cycle of each slot to avoid ghosting on the
    // previous digit while the segment lines settle.
    dig_en_d = '0;
    if (presc_q != '0) begin
      dig_en_d[idx_q] = 1'b1;
    end

    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= '0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// The reference model counts cycles since reset release and derives slot,
// digit and frame position from that count with plain arithmetic.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [4*N-1:0] bcd_in = '0;
  logic [6:0]   seg;
  logic [N-1:0] dig_en;
  logic         frame_done;
  logic         bcd_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: n = cycles since reset release; expected outputs for cycle n.
  int           n = 0;
  logic [15:0]  m_active = '0;
  logic [15:0]  m_pend = '0;
  logic         m_pflag = 1'b0;
  logic [6:0]   e_seg = '0;
  logic [N-1:0] e_dig = '0;
  logic         e_fd = 1'b0;
  logic         e_err = 1'b0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .load      (load),
    .seg       (seg),
    .dig_en    (dig_en),
    .frame_done(frame_done),
    .bcd_err   (bcd_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // Called at a negedge: check this cycle's outputs, drive inputs for the
  // coming edge, advance the model by one cycle, then wait for next negedge.
  task automatic cycle(input logic ld, input logic [15:0] val);
    int  presc;
    int  idx;
    int  code;
    bit  blank;
    chk("dig_en", 16'(dig_en), 16'(e_dig));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
    if (e_dig != '0) begin
      chk("seg", 16'(seg), 16'(e_seg));
      chk("bcd_err", 16'(bcd_err), 16'(e_err));
    end
    load   = ld;
    bcd_in = val;

    presc = n % R;
    idx   = (n / R) % N;
    code  = int'((m_active >> (4*idx)) & 16'hF);
    blank = 1'b0;
`ifdef SEG7_SCAN_LZ_BLANK_EN
    blank = (idx > 0) && ((m_active >> (4*idx)) == 16'h0);
`endif
    e_dig = (presc == 0) ? '0 : N'(1 << idx);
    e_seg = (blank || code > 9) ? 7'h00 : SEG_TAB[code];
    e_err = (code > 9);
    e_fd  = (((n + 1) % (R*N)) == 0);

    if (e_fd) begin
      if (ld) m_active = val;
      else if (m_pflag) m_active = m_pend;
      m_pflag = 1'b0;
    end else if (ld) begin
      m_pend  = val;
      m_pflag = 1'b1;
    end
    n++;
    @(negedge clk);
  endtask

  // Called at a negedge: one reset edge, check cleared outputs, release.
  task automatic do_reset();
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = '0;
    @(negedge clk);
    chk("rst_seg", 16'(seg), 16'h0);
    chk("rst_dig_en", 16'(dig_en), 16'h0);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_bcd_err", 16'(bcd_err), 16'h0);
    rst_n    = 1'b1;
    n        = 0;
    m_active = '0;
    m_pend   = '0;
    m_pflag  = 1'b0;
    e_seg    = '0;
    e_dig    = '0;
    e_fd     = 1'b0;
    e_err    = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 16'h0);
  endtask

  // Advance until the model cycle count sits at position t within a frame.
  task automatic run_to(input int t);
    for (int i = 0; i < R*N && (n % (R*N)) != t; i++) cycle(1'b0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld;
    logic [31:0] rv;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Free-running scan with value 0000.
    idle(40);

    // Mid-frame load of 1234.
    run_to(5);
    cycle(1'b1, 16'h1234);
    idle(40);

    // Two loads in one frame: last wins.
    run_to(2);
    cycle(1'b1, 16'h1111);
    idle(4);
    cycle(1'b1, 16'h5678);
    idle(36);

    // Invalid code in digit1.
    run_to(3);
    cycle(1'b1, 16'h00A9);
    idle(36);

    // Leading zeros.
    run_to(3);
    cycle(1'b1, 16'h0070);
    idle(36);

    // Load exactly on the frame-wrap cycle.
    run_to(R*N - 1);
    cycle(1'b1, 16'h4096);
    idle(36);

    // Reset during digit2 with a load pending.
    run_to(1);
    cycle(1'b1, 16'h9999);
    run_to(2*R + 1);
    do_reset();
    idle(40);

    // Randomized traffic, including invalid codes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rv = $urandom;
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        ld = ($urandom_range(0, 7) == 0);
        cycle(ld, rv[15:0]);
      end
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
